// File: rtl/fft_butterfly_sequencer.sv
// +-----------------------------------------------------------------------------------+
// | fft_butterfly_sequencer: in-place radix-2 DIT FFT butterfly/RAM-op sequencer       |
// | Revision 1.0                                                                       |
// +-----------------------------------------------------------------------------------+
`default_nettype none

module fft_butterfly_sequencer #(
  parameter int LOG2N     = 10,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 64,
  parameter int DATA_BASE = 0,
  parameter int TW_BASE   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] a_address,
  output logic [ADDR_W-1:0] b_address,
  output logic [ADDR_W-1:0] twiddle_address,
  output logic [DATA_W-1:0] a_write,
  output logic [DATA_W-1:0] b_write,
  input  logic [DATA_W-1:0] a_read,
  input  logic [DATA_W-1:0] b_read,
  input  logic [DATA_W-1:0] twiddle_read,
  input  logic              ready,
  output logic              bfly_start,
  output logic [DATA_W-1:0] bfly_a,
  output logic [DATA_W-1:0] bfly_b,
  output logic [DATA_W-1:0] bfly_tw,
  input  logic              bfly_done,
  input  logic [DATA_W-1:0] bfly_x,
  input  logic [DATA_W-1:0] bfly_y
);

  localparam int                IDX_W    = LOG2N + 1;
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  N_PTS    = IDX_W'(1) << LOG2N;
  localparam logic [3:0]        LAST_S   = 4'(LOG2N - 1);
  localparam logic [ADDR_W-1:0] DATA_B_A = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] TW_B_A   = ADDR_W'(TW_BASE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_BF   = 3'd2,
    S_WR   = 3'd3,
    S_ADV  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  j, g, j_nx, g_nx;
  logic [IDX_W-1:0]  half, span, half_nx;
  logic [3:0]        s_nx;
  logic              last_bfly, load_idx;
  logic [ADDR_W-1:0] a_nx, b_nx, tw_nx;

  assign half      = IDX_ONE << stage;
  assign span      = half << 1;
  assign last_bfly = (stage == LAST_S) && (j == half - IDX_ONE) && (g == N_PTS - span);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RD;
      S_RD:    if (ready) state_nx = S_BF;
      S_BF:    if (bfly_done) state_nx = S_WR;
      S_WR:    if (ready) state_nx = S_ADV;
      S_ADV:   state_nx = last_bfly ? S_DONE : S_RD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Index order: j innermost, then group base g, then stage.
  always_comb begin
    j_nx     = j;
    g_nx     = g;
    s_nx     = stage;
    load_idx = 1'b0;
    if (state == S_IDLE && start) begin
      load_idx = 1'b1;
      j_nx     = '0;
      g_nx     = '0;
      s_nx     = '0;
    end else if (state == S_ADV && !last_bfly) begin
      load_idx = 1'b1;
      if (j != half - IDX_ONE) begin
        j_nx = j + IDX_ONE;
      end else begin
        j_nx = '0;
        if (g != N_PTS - span) begin
          g_nx = g + span;
        end else begin
          g_nx = '0;
          s_nx = stage + 4'd1;
        end
      end
    end
  end

  assign half_nx = IDX_ONE << s_nx;
  assign a_nx    = DATA_B_A + ADDR_W'(g_nx) + ADDR_W'(j_nx);
  assign b_nx    = a_nx + ADDR_W'(half_nx);
  assign tw_nx   = TW_B_A + (ADDR_W'(j_nx) << (LAST_S - s_nx));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      read_enable     <= 1'b0;
      write_enable    <= 1'b0;
      bfly_start      <= 1'b0;
      j               <= '0;
      g               <= '0;
      stage           <= '0;
      a_address       <= '0;
      b_address       <= '0;
      twiddle_address <= '0;
      bfly_a          <= '0;
      bfly_b          <= '0;
      bfly_tw         <= '0;
      a_write         <= '0;
      b_write         <= '0;
    end else begin
      state        <= state_nx;
      busy         <= (state_nx == S_RD) || (state_nx == S_BF) ||
                      (state_nx == S_WR) || (state_nx == S_ADV);
      done         <= (state_nx == S_DONE);
      read_enable  <= (state_nx == S_RD);
      write_enable <= (state_nx == S_WR);
      bfly_start   <= (state == S_RD) && (state_nx == S_BF);
      if (load_idx) begin
        j               <= j_nx;
        g               <= g_nx;
        stage           <= s_nx;
        a_address       <= a_nx;
        b_address       <= b_nx;
        twiddle_address <= tw_nx;
      end
      if (state == S_RD && ready) begin
        bfly_a  <= a_read;
        bfly_b  <= b_read;
        bfly_tw <= twiddle_read;
      end
      if (state == S_BF && bfly_done) begin
        a_write <= bfly_x;
        b_write <= bfly_y;
      end
    end
  end

endmodule

`default_nettype wire
